// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: drives the register-file write port for ALU/jump results and
// runs loads/stores over a req/gnt/rvalid data bus, stalling upstream while an access is open.
module mem_wb_stage #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_ppl,
    input  logic [31:0] PC_ppl,
    input  logic [31:0] ALU_ppl,
    input  logic [31:0] rdata2_forwarded_ppl,
    output logic        reg_wr,
    output logic [31:0] wdata,
    output logic        stall,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    output logic        misalign,
    output logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT_CYC + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      state_q;
    logic [CW-1:0] cnt_q;
    logic        dbus_req_q;
    logic        dbus_we_q;
    logic [31:0] dbus_addr_q;
    logic [31:0] dbus_wdata_q;
    logic [3:0]  dbus_be_q;
    logic        bus_err_q;
    logic        is_ld_q;
    logic [2:0]  f3_q;
    logic [1:0]  a_q;
    logic [4:0]  rd_q;
    logic        ld_wr_q;
    logic [31:0] ld_data_q;
    logic        mis_seen_q;
    logic [31:0] mis_instr_q;
    logic [31:0] mis_pc_q;

    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        is_load;
    logic        is_store;
    logic        mis_addr;
    logic        mem_go;
    logic        mem_bad;
    logic        writes_rd;
    logic        is_link;
    logic [3:0]  lane_be_d;
    logic [31:0] lane_wd_d;

    assign opcode = instruction_ppl[6:2];
    assign rd     = instruction_ppl[11:7];
    assign f3     = instruction_ppl[14:12];

    always_comb begin
        is_load   = (opcode == OP_LOAD) && (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        is_store  = (opcode == OP_STORE) && (f3 inside {3'b000, 3'b001, 3'b010});
        mis_addr  = 1'b0;
        case (f3[1:0])
            2'b10:   mis_addr = (ALU_ppl[1:0] != 2'b00);
            2'b01:   mis_addr = ALU_ppl[0];
            default: mis_addr = 1'b0;
        endcase
        mem_go    = (is_load || is_store) && !mis_addr;
        mem_bad   = (is_load || is_store) && mis_addr;
        is_link   = (opcode == OP_JAL) || (opcode == OP_JALR);
        writes_rd = is_link || (opcode == OP_OPIMM) || (opcode == OP_OP) ||
                    (opcode == OP_LUI) || (opcode == OP_AUIPC);
    end

    // Store lanes; loads always fetch the full word and extract on return.
    always_comb begin
        lane_be_d = 4'b1111;
        lane_wd_d = 32'h0;
        if (is_store) begin
            case (f3[1:0])
                2'b00: begin
                    lane_be_d = 4'b0001 << ALU_ppl[1:0];
                    lane_wd_d = {4{rdata2_forwarded_ppl[7:0]}};
                end
                2'b01: begin
                    lane_be_d = ALU_ppl[1] ? 4'b1100 : 4'b0011;
                    lane_wd_d = {2{rdata2_forwarded_ppl[15:0]}};
                end
                default: begin
                    lane_be_d = 4'b1111;
                    lane_wd_d = rdata2_forwarded_ppl;
                end
            endcase
        end
    end

    function automatic logic [31:0] extract(input logic [2:0] fn, input logic [1:0] a,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (fn)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            dbus_req_q   <= 1'b0;
            dbus_we_q    <= 1'b0;
            dbus_addr_q  <= 32'h0;
            dbus_wdata_q <= 32'h0;
            dbus_be_q    <= 4'h0;
            bus_err_q    <= 1'b0;
            is_ld_q      <= 1'b0;
            f3_q         <= 3'h0;
            a_q          <= 2'h0;
            rd_q         <= 5'h0;
            ld_wr_q      <= 1'b0;
            ld_data_q    <= 32'h0;
            mis_seen_q   <= 1'b0;
            mis_instr_q  <= 32'h0;
            mis_pc_q     <= 32'h0;
        end else begin
            bus_err_q  <= 1'b0;
            // Remember the last dropped access so a held instruction pulses only once.
            mis_seen_q <= (state_q == S_IDLE) && mem_bad;
            if ((state_q == S_IDLE) && mem_bad) begin
                mis_instr_q <= instruction_ppl;
                mis_pc_q    <= PC_ppl;
            end
            case (state_q)
                S_IDLE: begin
                    if (mem_go) begin
                        state_q      <= S_REQ;
                        cnt_q        <= '0;
                        dbus_req_q   <= 1'b1;
                        dbus_we_q    <= is_store;
                        dbus_addr_q  <= {ALU_ppl[31:2], 2'b00};
                        dbus_wdata_q <= lane_wd_d;
                        dbus_be_q    <= lane_be_d;
                        is_ld_q      <= is_load;
                        f3_q         <= f3;
                        a_q          <= ALU_ppl[1:0];
                        rd_q         <= rd;
                        ld_wr_q      <= 1'b0;
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (dbus_gnt) begin
                        dbus_req_q <= 1'b0;
                        state_q    <= is_ld_q ? S_WAIT : S_DONE;
                    end else if (cnt_q >= CNT_LAST) begin
                        dbus_req_q <= 1'b0;
                        bus_err_q  <= 1'b1;
                        state_q    <= S_DONE;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (dbus_rvalid) begin
                        ld_data_q <= extract(f3_q, a_q, dbus_rdata);
                        ld_wr_q   <= (rd_q != 5'd0);
                        state_q   <= S_DONE;
                    end else if (cnt_q >= CNT_LAST) begin
                        bus_err_q <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ld_wr_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        reg_wr = 1'b0;
        wdata  = ALU_ppl;
        if (!rst) begin
            if (state_q == S_IDLE) begin
                reg_wr = writes_rd && (rd != 5'd0);
                wdata  = is_link ? (PC_ppl + 32'd4) : ALU_ppl;
            end else if (state_q == S_DONE) begin
                reg_wr = ld_wr_q;
                wdata  = ld_data_q;
            end
        end
    end

    assign stall = !rst && (((state_q == S_IDLE) && mem_go) ||
                            (state_q == S_REQ) || (state_q == S_WAIT));
    assign misalign = !rst && (state_q == S_IDLE) && mem_bad &&
                      !(mis_seen_q && (instruction_ppl == mis_instr_q) && (PC_ppl == mis_pc_q));

    assign bus_err    = bus_err_q;
    assign dbus_req   = dbus_req_q;
    assign dbus_we    = dbus_we_q;
    assign dbus_addr  = dbus_addr_q;
    assign dbus_wdata = dbus_wdata_q;
    assign dbus_be    = dbus_be_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed and randomized checks of mem_wb_stage against a small behavioural model of
// the write-back, byte-lane, load-extract, misalignment and timeout rules.
module tb_mem_wb_stage;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction_ppl, PC_ppl, ALU_ppl, rdata2_forwarded_ppl;
    logic        reg_wr, stall, dbus_req, dbus_we, misalign, bus_err;
    logic [31:0] wdata, dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;
    logic        dbus_gnt, dbus_rvalid;

    int errors = 0;
    int checks = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    logic [4:0] wr_ops [6] = '{5'b00100, 5'b01100, 5'b01101, 5'b00101, 5'b11011, 5'b11001};
    logic [4:0] any_ops [9] = '{5'b00100, 5'b01100, 5'b01101, 5'b00101, 5'b11011, 5'b11001,
                                5'b11000, 5'b11100, 5'b00011};
    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    mem_wb_stage #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .instruction_ppl(instruction_ppl), .PC_ppl(PC_ppl), .ALU_ppl(ALU_ppl),
        .rdata2_forwarded_ppl(rdata2_forwarded_ppl),
        .reg_wr(reg_wr), .wdata(wdata), .stall(stall),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_be(dbus_be),
        .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [2:0] f3);
        logic [16:0] hi;
        hi = 17'($urandom);
        return {hi, f3, rd, op, 2'b11};
    endfunction

    function automatic bit model_writes(input logic [4:0] op);
        foreach (wr_ops[i]) if (wr_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_be(input bit is_st, input logic [2:0] f3, input int a);
        if (!is_st || f3 == 3'b010) return 4'hF;
        if (f3 == 3'b000) return 4'(1 << a);
        return (a >= 2) ? 4'hC : 4'h3;
    endfunction

    function automatic logic [31:0] model_swd(input logic [2:0] f3, input logic [31:0] rs2);
        if (f3 == 3'b000) return 32'(rs2[7:0]) * 32'h0101_0101;
        if (f3 == 3'b001) return 32'(rs2[15:0]) * 32'h0001_0001;
        return rs2;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int a,
                                               input logic [31:0] w);
        int v;
        case (f3)
            3'b000, 3'b100: begin
                v = int'((w >> (8 * a)) & 32'hFF);
                if (f3 == 3'b000 && v >= 128) v -= 256;
            end
            3'b001, 3'b101: begin
                v = int'((w >> (16 * (a / 2))) & 32'hFFFF);
                if (f3 == 3'b001 && v >= 32768) v -= 65536;
            end
            default: return w;
        endcase
        return 32'(v);
    endfunction

    task automatic alu_op(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] alu,
                          input string tag);
        bit exp_wr;
        logic [31:0] exp_wd;
        exp_wr = model_writes(ins[6:2]) && (ins[11:7] != 0);
        exp_wd = (ins[6:2] == 5'b11011 || ins[6:2] == 5'b11001) ? pc + 32'd4 : alu;
        @(posedge clk); #1;
        instruction_ppl = ins; PC_ppl = pc; ALU_ppl = alu;
        rdata2_forwarded_ppl = $urandom; dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
        @(negedge clk);
        chk({tag, ".reg_wr"}, reg_wr, exp_wr);
        if (exp_wr) chk({tag, ".wdata"}, wdata, exp_wd);
        chk({tag, ".stall"}, stall, 0);
        chk({tag, ".req"}, dbus_req, 0);
        $display("txn %s op=%b rd=%0d reg_wr=%0b wdata=%h", tag, ins[6:2], ins[11:7], reg_wr, wdata);
    endtask

    task automatic mem_txn(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] rs2,
                           input logic [31:0] rdat, input int gd, input int rvd, input string tag);
        bit ld, done, exp_wr;
        logic [2:0] f3;
        int a, n, stalls;
        logic [31:0] exp_ld;
        ld = (ins[6:2] == 5'b00000);
        f3 = ins[14:12];
        a = int'(alu[1:0]);
        exp_wr = ld && (ins[11:7] != 0);
        exp_ld = model_load(f3, a, rdat);
        pc_ctr += 4;
        @(posedge clk); #1;
        instruction_ppl = ins; PC_ppl = pc_ctr; ALU_ppl = alu; rdata2_forwarded_ppl = rs2;
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
        @(negedge clk);
        chk({tag, ".idle_stall"}, stall, 1);
        chk({tag, ".idle_req"}, dbus_req, 0);
        chk({tag, ".misalign"}, misalign, 0);
        stalls = 1;
        n = 0; done = 0;
        while (!done && n < TO) begin
            @(posedge clk); #1;
            dbus_gnt = (n == gd);
            @(negedge clk);
            chk({tag, ".req"}, dbus_req, 1);
            chk({tag, ".addr"}, dbus_addr, alu & 32'hFFFF_FFFC);
            chk({tag, ".we"}, dbus_we, !ld);
            chk({tag, ".be"}, dbus_be, model_be(!ld, f3, a));
            if (!ld) chk({tag, ".bus_wdata"}, dbus_wdata, model_swd(f3, rs2));
            if (stall) stalls++;
            if (dbus_gnt) done = 1;
            n++;
        end
        chk({tag, ".granted"}, done, 1);
        if (ld) begin
            n = 0; done = 0;
            while (!done && n < TO) begin
                @(posedge clk); #1;
                dbus_gnt = 1'b0;
                n++;
                dbus_rvalid = (n == rvd);
                dbus_rdata = dbus_rvalid ? rdat : $urandom;
                @(negedge clk);
                chk({tag, ".wait_req"}, dbus_req, 0);
                if (stall) stalls++;
                if (dbus_rvalid) done = 1;
            end
            chk({tag, ".rvalid_taken"}, done, 1);
        end
        @(posedge clk); #1;
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = $urandom;
        @(negedge clk);
        chk({tag, ".done_stall"}, stall, 0);
        chk({tag, ".done_reg_wr"}, reg_wr, exp_wr);
        if (exp_wr) chk({tag, ".done_wdata"}, wdata, exp_ld);
        chk({tag, ".bus_err"}, bus_err, 0);
        chk({tag, ".stall_cycles"}, stalls, 1 + gd + 1 + (ld ? rvd : 0));
        $display("txn %s %s f3=%0d addr=%h gd=%0d rvd=%0d stall_cycles=%0d reg_wr=%0b wdata=%h",
                 tag, ld ? "load" : "store", f3, alu, gd, rvd, stalls, reg_wr, wdata);
    endtask

    task automatic misal(input logic [31:0] ins, input logic [31:0] alu, input int hold,
                         input string tag);
        int pulses;
        pulses = 0;
        pc_ctr += 4;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                instruction_ppl = ins; PC_ppl = pc_ctr; ALU_ppl = alu;
                rdata2_forwarded_ppl = $urandom; dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
            end
            @(negedge clk);
            if (misalign) pulses++;
            chk({tag, ".stall"}, stall, 0);
            chk({tag, ".req"}, dbus_req, 0);
            chk({tag, ".reg_wr"}, reg_wr, 0);
        end
        chk({tag, ".pulses"}, pulses, 1);
        $display("txn %s misaligned addr=%h held=%0d pulses=%0d", tag, alu, hold, pulses);
    endtask

    initial begin
        logic [31:0] ins, alu;
        int kind, gd, rvd;
        logic [2:0] f3;
        int n;

        rst = 1'b1;
        instruction_ppl = mk(5'b11000, 5'd0, 3'b000);
        PC_ppl = 32'h0; ALU_ppl = 32'h0; rdata2_forwarded_ppl = 32'h0;
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.reg_wr", reg_wr, 0);
        chk("reset.stall", stall, 0);
        chk("reset.req", dbus_req, 0);
        chk("reset.we", dbus_we, 0);
        chk("reset.be", dbus_be, 0);
        chk("reset.misalign", misalign, 0);
        chk("reset.bus_err", bus_err, 0);
        rst = 1'b0;
        $display("txn reset released");

        alu_op(mk(5'b00100, 5'd5, 3'b000), 32'h200, 32'h1234, "addi_x5");
        alu_op(mk(5'b11011, 5'd1, 3'b000), 32'h100, 32'hDEAD_0000, "jal_x1");
        alu_op(mk(5'b11011, 5'd0, 3'b000), 32'h100, 32'hDEAD_0000, "jal_x0");
        alu_op(mk(5'b11000, 5'd9, 3'b001), 32'h300, 32'h5555, "beq");
        mem_txn(mk(5'b00000, 5'd6, 3'b000), 32'h2003, 32'h0, 32'h80FF_FF00, 2, 3, "lb_x6");
        mem_txn(mk(5'b01000, 5'd3, 3'b001), 32'h10, 32'hABCD_1234, 32'h0, 0, 0, "sh");
        misal(mk(5'b00000, 5'd3, 3'b010), 32'h2002, 4, "lw_misaligned");
        mem_txn(mk(5'b00000, 5'd0, 3'b010), 32'h4000, 32'h0, 32'h1111_2222, 1, 1, "lw_x0");

        // Timeout: gnt never arrives.
        pc_ctr += 4;
        @(posedge clk); #1;
        instruction_ppl = mk(5'b00000, 5'd8, 3'b010); PC_ppl = pc_ctr; ALU_ppl = 32'h5000;
        @(negedge clk);
        n = 0;
        for (int i = 0; i < TO + 8; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (!dbus_req) break;
            n++;
        end
        chk("timeout.req_cycles", n, TO);
        chk("timeout.bus_err", bus_err, 1);
        chk("timeout.reg_wr", reg_wr, 0);
        chk("timeout.stall", stall, 0);
        @(posedge clk); #1;
        instruction_ppl = mk(5'b11000, 5'd0, 3'b000);
        dbus_gnt = 1'b1; dbus_rvalid = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("timeout.late_reg_wr", reg_wr, 0);
        chk("timeout.late_req", dbus_req, 0);
        chk("timeout.bus_err_once", bus_err, 0);
        $display("txn timeout req_cycles=%0d", n);

        // Reset while waiting for load data.
        pc_ctr += 4;
        @(posedge clk); #1;
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
        instruction_ppl = mk(5'b00000, 5'd7, 3'b010); PC_ppl = pc_ctr; ALU_ppl = 32'h3000;
        @(posedge clk); #1;
        dbus_gnt = 1'b1;
        @(posedge clk); #1;
        dbus_gnt = 1'b0;
        @(negedge clk);
        chk("rst_wait.in_wait_stall", stall, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        dbus_rvalid = 1'b1; dbus_rdata = 32'h7777_7777;
        @(negedge clk);
        chk("rst_wait.req", dbus_req, 0);
        chk("rst_wait.stall", stall, 0);
        chk("rst_wait.reg_wr", reg_wr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        instruction_ppl = mk(5'b11000, 5'd0, 3'b000);
        @(negedge clk);
        chk("rst_wait.after_req", dbus_req, 0);
        chk("rst_wait.after_stall", stall, 0);
        chk("rst_wait.after_reg_wr", reg_wr, 0);
        chk("rst_wait.after_be", dbus_be, 0);
        @(posedge clk); #1;
        dbus_rvalid = 1'b0;
        $display("txn reset_in_wait");

        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 3);
            alu = $urandom;
            gd = $urandom_range(0, 3);
            rvd = $urandom_range(1, 3);
            if (kind == 0) begin
                ins = mk(any_ops[$urandom_range(0, 8)], 5'($urandom), 3'($urandom));
                pc_ctr += 4;
                alu_op(ins, pc_ctr, alu, "rnd_alu");
            end else if (kind == 1 || kind == 2) begin
                if (kind == 1) begin
                    f3 = ld_f3[$urandom_range(0, 4)];
                    ins = mk(5'b00000, 5'($urandom), f3);
                end else begin
                    f3 = 3'($urandom_range(0, 2));
                    ins = mk(5'b01000, 5'($urandom), f3);
                end
                if (f3[1:0] == 2'b10) alu[1:0] = 2'b00;
                if (f3[1:0] == 2'b01) alu[0] = 1'b0;
                mem_txn(ins, alu, $urandom, $urandom, gd, rvd, kind == 1 ? "rnd_load" : "rnd_store");
            end else begin
                f3 = 3'($urandom_range(1, 2));
                ins = mk($urandom_range(0, 1) ? 5'b01000 : 5'b00000, 5'($urandom), f3);
                if (f3 == 3'b010) alu[1:0] = 2'($urandom_range(1, 3));
                else alu[0] = 1'b1;
                misal(ins, alu, $urandom_range(1, 3), "rnd_misalign");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
